// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative signed multiply/divide engine owning HI/LO (optional HILO_FAST_MULT_EN)
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    input  logic             read_en,
    input  logic             read_sel,
    output logic [WIDTH-1:0] read_data,
    output logic             stall,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data
);

    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier bits being consumed / dividend bits shifting into quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             op_div;
    logic             div_zero;

    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   a_back;

`ifdef HILO_FAST_MULT_EN
    logic signed [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed(src_a) * $signed(src_b);
`endif

    // Ops 00/11 are not operations; only MULT/DIV can leave IDLE.
    assign accept = start && (op == OP_MULT || op == OP_DIV);

    // Magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;

    // One shift-add step: conditionally add the multiplicand, then shift right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);

    // One restoring-division step: bring in the next dividend bit and trial-subtract.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_b};

    // Sign correction applied in the FIX cycle.
    assign prod_raw = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;
    assign q_fix    = neg_q ? -acc_lo : acc_lo;
    assign r_fix    = neg_r ? -acc_hi : acc_hi;
    // Divide by zero returns the original dividend in HI; rebuild it from magnitude and sign.
    assign a_back   = neg_r ? -mag_a : mag_a;

    // Read port and interlock are purely combinational on the architectural registers.
    assign read_data = read_sel ? hi : lo;
    assign stall     = read_en & busy;

    // Operation sequencer plus HI/LO update (FIX edge or IDLE mthi/mtlo).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Start wins over a simultaneous mthi/mtlo; the write is dropped.
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        neg_q    <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        neg_r    <= src_a[WIDTH-1];
                        op_div   <= (op == OP_DIV);
                        div_zero <= (src_b == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        acc_hi   <= '0;
                        acc_lo   <= (op == OP_DIV) ? abs_a : abs_b;
                        state    <= S_CALC;
`ifdef HILO_FAST_MULT_EN
                        if (op == OP_MULT) begin
                            {acc_hi, acc_lo} <= fast_prod;
                            neg_q            <= 1'b0;
                            state            <= S_FIX;
                        end
`endif
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_div) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a_back;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine that owns the architectural HI/LO registers.
- Sits beside the execute stage. The pipeline issues MULT/DIV to it, and later mfhi/mflo instructions read HI/LO through its read port.
- It raises a stall while a read targets a result that is still being computed.
- mthi/mtlo writes also land here.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  issue request, sampled on a clk edge
- op  input  2  operation: 2'b01 MULT, 2'b10 DIV; 2'b00 and 2'b11 are ignored
- src_a  input  WIDTH  signed operand A (dividend for DIV)
- src_b  input  WIDTH  signed operand B (divisor for DIV)
- busy  output  1  high while an operation is in flight
- read_en  input  1  mfhi/mflo in the consuming stage
- read_sel  input  1  0 selects LO, 1 selects HI
- read_data  output  WIDTH  combinational value of the selected register
- stall  output  1  combinational, equal to read_en & busy
- wr_hi  input  1  mthi strobe
- wr_lo  input  1  mtlo strobe
- wr_data  input  WIDTH  mthi/mtlo data

Behaviour:
- Reset:
  - reset_n low forces, asynchronously: state=IDLE, hi=0, lo=0, busy=0, counter=0, internal accumulators=0.
  - Reset mid-operation discards the operation; HI/LO read 0 afterwards.
- State machine:
  - IDLE -> CALC: on start & (op==01 | op==10). Latch |src_a|, |src_b|, the result sign(s) and op; counter=0; busy=1 from this edge.
  - CALC: one iteration per cycle; counter increments. CALC -> FIX when counter==WIDTH-1 (WIDTH cycles in CALC).
  - FIX -> IDLE: apply sign correction, write HI and LO, busy=0 on the same edge.
- Latency:
  - start sampled at edge E0; HI/LO updated and busy falls at edge E(WIDTH+1), i.e. E33 at default.
  - A read in the cycle after E33 returns the new value.
- MULT:
  - Radix-2 shift-add on magnitudes, giving a 2*WIDTH-bit product.
  - Negate if sign(a)^sign(b).
  - HI = product[63:32], LO = product[31:0].
- DIV:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
  - -2^31 / -1: LO = 32'h80000000, HI = 0.
- Divide by zero (src_b==0): still takes the full latency. Result is LO = 32'hFFFFFFFF, HI = src_a.
- start while busy is ignored. No queueing; the issuing stage must hold off using busy.
- op 00/11 with start: no effect, stays IDLE.
- mthi/mtlo:
  - When IDLE, wr_hi/wr_lo write wr_data at the clock edge. Both asserted write both registers.
  - Writes while busy are dropped.
  - start together with a write while IDLE: start wins, write dropped.
- Read port:
  - read_data = read_sel ? hi : lo. It always reflects the current registers, and holds pre-operation values while busy.
  - stall is asserted with read_en whenever busy, including the FIX cycle.
- HI/LO change only at the FIX edge, on an IDLE write, or on reset.

Optional Feature:
- Macro: HILO_FAST_MULT_EN.
- Defined:
  - MULT uses a single-cycle combinational signed WIDTH x WIDTH product.
  - IDLE -> FIX directly; HI/LO written and busy falls at E1 (busy high for one cycle).
  - DIV is unchanged.
- Undefined: MULT is iterative with latency WIDTH+1, as above.
- Read/stall semantics are identical in both builds.

Test Plan:
- Reset: reset_n=0 mid-DIV at cycle 10 -> busy=0 immediately; read_sel=0/1 give 0/0; stall=0.
- MULT 7 x -3: start at E0 -> busy high E0..E33; after E33, LO=32'hFFFFFFEB, HI=32'hFFFFFFFF. Repeat 32'h7FFFFFFF x 2 -> HI=0, LO=32'hFFFFFFFE.
- DIV -7 / 2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIV -2^31 / -1 -> LO=32'h80000000, HI=0. DIV 5 / 0 -> LO=32'hFFFFFFFF, HI=5.
- Stall interlock: read_en=1, read_sel=1 from E1 to E33 during MULT -> stall=1 every cycle through the FIX cycle, read_data = old HI; stall=0 after E33 and read_data = new HI.
- Busy collisions:
  - Second start at E5 -> ignored; result matches the first op only.
  - wr_lo=1, wr_data=32'h1234 at E5 -> dropped.
  - Same write while IDLE -> LO=32'h1234.
  - start with wr_hi in the same IDLE cycle -> HI set by the op result, not wr_data.
- HILO_FAST_MULT_EN defined: MULT -4 x -4 -> busy high for one cycle; after E1, LO=16, HI=0. DIV latency is still 33.
